// File: rtl/noc_link_pkg.sv
// Shared types for the credit-based NoC link: credit-count width helper and
// the monitor state (credit count, packet tracker, sticky error flags).
package noc_link_pkg;

  // Storage widths for the monitor struct; the top requires
  // $clog2(FLIT_BUFFER_DEPTH+1) <= MON_CNT_W and DEST_WIDTH <= MON_DEST_W.
  localparam int unsigned MON_CNT_W  = 16;
  localparam int unsigned MON_DEST_W = 32;

  typedef struct packed {
    logic [MON_CNT_W-1:0]  count;
    logic                  pkt_active;
    logic [MON_DEST_W-1:0] head_dest;
    logic                  err_overflow;
    logic                  err_underflow;
    logic                  err_dest;
  } mon_state_t;

  function automatic int unsigned credit_cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/noc_link_stage.sv
// One register slice of the link: forward flit fields and reverse credit bit,
// all cleared asynchronously so in-flight traffic is dropped on reset.
module noc_link_stage #(
  parameter int FLIT_WIDTH = 64,
  parameter int DEST_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FLIT_WIDTH-1:0] data_in,
  input  logic [DEST_WIDTH-1:0] dest_in,
  input  logic                  is_tail_in,
  input  logic                  send_in,
  input  logic                  credit_in,
  output logic [FLIT_WIDTH-1:0] data_out,
  output logic [DEST_WIDTH-1:0] dest_out,
  output logic                  is_tail_out,
  output logic                  send_out,
  output logic                  credit_out
);

  logic [FLIT_WIDTH-1:0] data_q, data_d;
  logic [DEST_WIDTH-1:0] dest_q, dest_d;
  logic                  is_tail_q, is_tail_d;
  logic                  send_q, send_d;
  logic                  credit_q, credit_d;

  always_comb begin
    data_d    = data_in;
    dest_d    = dest_in;
    is_tail_d = is_tail_in;
    send_d    = send_in;
    credit_d  = credit_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      dest_q    <= '0;
      is_tail_q <= 1'b0;
      send_q    <= 1'b0;
      credit_q  <= 1'b0;
    end else begin
      data_q    <= data_d;
      dest_q    <= dest_d;
      is_tail_q <= is_tail_d;
      send_q    <= send_d;
      credit_q  <= credit_d;
    end
  end

  assign data_out    = data_q;
  assign dest_out    = dest_q;
  assign is_tail_out = is_tail_q;
  assign send_out    = send_q;
  assign credit_out  = credit_q;

endmodule

// File: rtl/noc_credit_link.sv
// Pipelined credit-based NoC link with a passive monitor that tracks sender
// credits, packet framing and destination consistency.
module noc_credit_link
  import noc_link_pkg::*;
#(
  parameter int FLIT_WIDTH        = 64,
  parameter int DEST_WIDTH        = 4,
  parameter int NUM_PIPELINE      = 2,
  parameter int FLIT_BUFFER_DEPTH = 4
) (
  input  logic                                   clk_noc,
  input  logic                                   rst_n,
  input  logic [FLIT_WIDTH-1:0]                  data_in,
  input  logic [DEST_WIDTH-1:0]                  dest_in,
  input  logic                                   is_tail_in,
  input  logic                                   send_in,
  output logic                                   credit_out,
  output logic [FLIT_WIDTH-1:0]                  data_out,
  output logic [DEST_WIDTH-1:0]                  dest_out,
  output logic                                   is_tail_out,
  output logic                                   send_out,
  input  logic                                   credit_in,
  output logic [$clog2(FLIT_BUFFER_DEPTH+1)-1:0] credit_count,
  output logic                                   pkt_active,
  output logic                                   err_overflow,
  output logic                                   err_underflow,
  output logic                                   err_dest,
  input  logic                                   err_clear
);

  localparam int CNT_W = credit_cnt_width(FLIT_BUFFER_DEPTH);

  // Handshake: there is no ready; send_* and credit_* are single-cycle valid
  // pulses that every stage accepts unconditionally, one per cycle.
  logic [FLIT_WIDTH-1:0] data_s    [NUM_PIPELINE+1];
  logic [DEST_WIDTH-1:0] dest_s    [NUM_PIPELINE+1];
  logic                  is_tail_s [NUM_PIPELINE+1];
  logic                  send_s    [NUM_PIPELINE+1];
  logic                  credit_s  [NUM_PIPELINE+1];

  assign data_s[0]    = data_in;
  assign dest_s[0]    = dest_in;
  assign is_tail_s[0] = is_tail_in;
  assign send_s[0]    = send_in;
  assign credit_s[0]  = credit_in;

  for (genvar i = 0; i < NUM_PIPELINE; i++) begin : g_stage
    noc_link_stage #(
      .FLIT_WIDTH(FLIT_WIDTH),
      .DEST_WIDTH(DEST_WIDTH)
    ) u_stage (
      .clk        (clk_noc),
      .rst_n      (rst_n),
      .data_in    (data_s[i]),
      .dest_in    (dest_s[i]),
      .is_tail_in (is_tail_s[i]),
      .send_in    (send_s[i]),
      .credit_in  (credit_s[i]),
      .data_out   (data_s[i+1]),
      .dest_out   (dest_s[i+1]),
      .is_tail_out(is_tail_s[i+1]),
      .send_out   (send_s[i+1]),
      .credit_out (credit_s[i+1])
    );
  end

  assign data_out    = data_s[NUM_PIPELINE];
  assign dest_out    = dest_s[NUM_PIPELINE];
  assign is_tail_out = is_tail_s[NUM_PIPELINE];
  assign send_out    = send_s[NUM_PIPELINE];
  assign credit_out  = credit_s[NUM_PIPELINE];

  localparam mon_state_t MON_RST = '{
    count:         MON_CNT_W'(FLIT_BUFFER_DEPTH),
    pkt_active:    1'b0,
    head_dest:     '0,
    err_overflow:  1'b0,
    err_underflow: 1'b0,
    err_dest:      1'b0
  };

  mon_state_t mon_q, mon_d;

  // Credits are spent by send_in and returned by credit_out (what the
  // upstream router actually sees); simultaneous events cancel.
  always_comb begin
    mon_d = mon_q;
    if (err_clear) begin
      mon_d.err_overflow  = 1'b0;
      mon_d.err_underflow = 1'b0;
      mon_d.err_dest      = 1'b0;
    end
    if (send_in && !credit_out) begin
      if (mon_q.count == '0) mon_d.err_overflow = 1'b1;
      else                   mon_d.count = mon_q.count - MON_CNT_W'(1);
    end else if (credit_out && !send_in) begin
      if (mon_q.count == MON_CNT_W'(FLIT_BUFFER_DEPTH)) mon_d.err_underflow = 1'b1;
      else mon_d.count = mon_q.count + MON_CNT_W'(1);
    end
    if (send_in) begin
      if (mon_q.pkt_active) begin
        if (mon_q.head_dest != MON_DEST_W'(dest_in)) mon_d.err_dest = 1'b1;
        if (is_tail_in) mon_d.pkt_active = 1'b0;
      end else if (!is_tail_in) begin
        mon_d.pkt_active = 1'b1;
        mon_d.head_dest  = MON_DEST_W'(dest_in);
      end
    end
  end

  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) mon_q <= MON_RST;
    else        mon_q <= mon_d;
  end

  assign credit_count  = mon_q.count[CNT_W-1:0];
  assign pkt_active    = mon_q.pkt_active;
  assign err_overflow  = mon_q.err_overflow;
  assign err_underflow = mon_q.err_underflow;
  assign err_dest      = mon_q.err_dest;

endmodule

// File: doc/noc_credit_link.md
NOC_CREDIT_LINK -- requirements
Module: noc_credit_link

Interface
REQ-001 The block SHALL have parameter FLIT_WIDTH, default 64, flit payload width.
REQ-002 The block SHALL have parameter DEST_WIDTH, default 4, destination field width.
REQ-003 The block SHALL have parameter NUM_PIPELINE, default 2, number of register stages per direction (0 allowed).
REQ-004 The block SHALL have parameter FLIT_BUFFER_DEPTH, default 4, downstream input buffer depth, which is also the initial credit count.
REQ-005 The block SHALL have port clk_noc, input, 1 bit, single clock.
REQ-006 The block SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-007 The block SHALL have ports data_in / dest_in / is_tail_in / send_in, inputs, FLIT_WIDTH / DEST_WIDTH / 1 / 1 bits, flit from the upstream router.
REQ-008 The block SHALL have port credit_out, output, 1 bit, credit returned to the upstream router.
REQ-009 The block SHALL have ports data_out / dest_out / is_tail_out / send_out, outputs, FLIT_WIDTH / DEST_WIDTH / 1 / 1 bits, flit to the downstream router.
REQ-010 The block SHALL have port credit_in, input, 1 bit, credit from the downstream router.
REQ-011 The block SHALL have port credit_count, output, $clog2(FLIT_BUFFER_DEPTH+1) bits, credits currently available to the upstream sender.
REQ-012 The block SHALL have port pkt_active, output, 1 bit, high between a non-tail head flit and its tail flit.
REQ-013 The block SHALL have ports err_overflow / err_underflow / err_dest, outputs, 1 bit each, sticky error flags.
REQ-014 The block SHALL have port err_clear, input, 1 bit, synchronous clear of all sticky error flags.

Function
REQ-015 Forward path: {data,dest,is_tail,send}_out SHALL equal {data,dest,is_tail,send}_in delayed by exactly NUM_PIPELINE clk_noc cycles; with NUM_PIPELINE=0 the path SHALL be combinational.
REQ-016 Reverse path: credit_out SHALL equal credit_in delayed by exactly NUM_PIPELINE cycles; with NUM_PIPELINE=0 the path SHALL be combinational.
REQ-017 The pipeline SHALL have no stall or backpressure; a flit or credit pulse SHALL be accepted every cycle and SHALL never be dropped or duplicated.
REQ-018 credit_count SHALL decrement on send_in only, increment on credit_out only, and stay unchanged when both are high or both are low.
REQ-019 Overflow: send_in with credit_count==0 and credit_out low SHALL set err_overflow, and credit_count SHALL hold at 0.
REQ-020 Underflow: credit_out with credit_count==FLIT_BUFFER_DEPTH and send_in low SHALL set err_underflow, and credit_count SHALL hold at FLIT_BUFFER_DEPTH.
REQ-021 Packet tracker: send_in && !is_tail_in && !pkt_active SHALL set pkt_active and capture dest_in as the head destination; send_in && is_tail_in SHALL clear pkt_active on the next cycle.
REQ-022 A flit with send_in && pkt_active whose dest_in differs from the captured head destination SHALL set err_dest; that flit SHALL still be forwarded unchanged.
REQ-023 A single-flit packet (send_in && is_tail_in while !pkt_active) SHALL leave pkt_active low.
REQ-024 Error flags SHALL stay set until err_clear; if err_clear coincides with a new error event, the flag SHALL be set (set wins).
REQ-025 Monitor logic SHALL NOT affect the data or credit paths.

Reset
REQ-026 When rst_n is low, all stage send/credit bits, the data/dest/tail stage registers, pkt_active and all error flags SHALL be 0, and credit_count SHALL be FLIT_BUFFER_DEPTH, asynchronously.
REQ-027 Flits or credits in flight at reset assertion SHALL be discarded; the first cycle after deassertion SHALL output send_out=0 and credit_out=0 when NUM_PIPELINE>0.

Structure
REQ-028 Package noc_link_pkg SHALL hold the credit-count width function and the monitor-state struct (count, pkt_active, head destination, error flags).
REQ-029 One sub-module, noc_link_stage, SHALL implement a single register stage for the forward flit and reverse credit; it SHALL be instantiated NUM_PIPELINE times in a generate loop.

Verification
REQ-030 NUM_PIPELINE=2, send_in pulse with data 0xA5, dest 3 -> send_out with data 0xA5, dest 3 exactly 2 cycles later; credit_in pulse -> credit_out 2 cycles later.
REQ-031 DEPTH=4, 4 back-to-back sends with no credits -> credit_count 4,3,2,1,0; a 5th send -> err_overflow=1 and count holds at 0.
REQ-032 Simultaneous send_in and credit_out at count=2 -> count stays 2; credit with count=4 and no send -> err_underflow=1.
REQ-033 Head with dest 5, body with dest 6, tail with dest 5 -> err_dest=1, pkt_active 1 from head until the cycle after the tail, all three flits forwarded intact.
REQ-034 Set err_overflow, then assert err_clear together with a new overflow event -> flag stays 1; err_clear alone -> 0 next cycle.
REQ-035 Assert rst_n low mid-stream with flits in all stages -> outputs 0 immediately, count=4, no stale send_out after release; repeat with NUM_PIPELINE=0 to check combinational pass-through.
